ysyx_22050039_inst_fetch: RTL and testbench

- Fetch front end directly upstream of the CPU top.
- Takes the core's pc and issues one read request per instruction to a variable-latency instruction memory over a valid/ready bus.
- Selects the 32-bit instruction from the 64-bit response and presents it to the core with a valid/ready handshake.
- Handles redirects (flush), including dropping in-flight stale responses. At most one outstanding request.

---
 rtl/ysyx_22050039_inst_fetch_pkg.sv | 27 ++
 rtl/ysyx_22050039_inst_fetch_if.sv | 38 +++
 rtl/ysyx_22050039_inst_fetch_perf.sv | 28 ++
 rtl/ysyx_22050039_inst_fetch.sv | 172 +++++++++++++++++
 tb/tb_ysyx_22050039_inst_fetch.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050039_inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Imported by the fetch top, its bus interface and the perf sub-module.
package ysyx_22050039_ifetch_pkg;

    // Default widths: address/pc, instruction, memory response beat.
    localparam int XLEN_DEF     = 64;
    localparam int INST_LEN_DEF = 32;
    localparam int MEM_DW_DEF   = 64;

    // Instruction presented while nothing has been fetched yet (addi x0, x0, 0).
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,  // no fetch wanted
        S_REQ   = 3'd1,  // request presented to memory
        S_WAIT  = 3'd2,  // request accepted, response pending
        S_DONE  = 3'd3,  // instruction offered to the core
        S_DRAIN = 3'd4   // redirected while a response is pending; discard it
    } ifetch_state_e;

    // States in which the front end is waiting on memory rather than the core.
    function automatic logic is_stall_state(input ifetch_state_e s);
        return (s == S_REQ) || (s == S_WAIT) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/ysyx_22050039_inst_fetch_if.sv
// Instruction memory bus: one read request channel and one response channel.
// The fetch unit is the master; the instruction memory is the slave.
interface ysyx_22050039_inst_fetch_if
    import ysyx_22050039_ifetch_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int MEM_DW = MEM_DW_DEF
) ();

    // Request channel
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_req_addr;

    // Response channel (no back-pressure from the fetch unit)
    logic              mem_resp_valid;
    logic [MEM_DW-1:0] mem_resp_data;
    logic              mem_resp_err;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        input  mem_resp_err
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        output mem_resp_err
    );

endinterface

// File: rtl/ysyx_22050039_inst_fetch_perf.sv
// Performance counters for the fetch front end: delivered instructions,
// cycles spent waiting on memory, and accepted redirects.
// Only instantiated when YSYX_22050039_IFETCH_PERF_EN is defined.
module ysyx_22050039_ifetch_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [63:0] fetch_cnt,
    output logic [63:0] stall_cnt,
    output logic [63:0] flush_cnt
);

    // Free-running counters; they wrap naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (fetch_inc) fetch_cnt <= fetch_cnt + 64'd1;
            if (stall_inc) stall_cnt <= stall_cnt + 64'd1;
            if (flush_inc) flush_cnt <= flush_cnt + 64'd1;
        end
    end

endmodule

// File: rtl/ysyx_22050039_inst_fetch.sv
// Instruction fetch front end. Issues one doubleword read per instruction,
// picks the 32-bit half selected by pc[2], and hands it to the core with a
// valid/ready handshake. A flush redirects the fetch; a response belonging to
// an abandoned request is drained and dropped. At most one request is ever
// outstanding.
// Optional: define YSYX_22050039_IFETCH_PERF_EN to add perf_fetch, perf_stall
// and perf_flush counter outputs.
module ysyx_22050039_inst_fetch
    import ysyx_22050039_ifetch_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int INST_LEN = INST_LEN_DEF,
    parameter int MEM_DW   = MEM_DW_DEF     // must be 2*INST_LEN
) (
    input  logic                 clk,
    input  logic                 rst,

    // Core side
    input  logic [XLEN-1:0]      pc,
    input  logic                 pc_valid,
    input  logic                 flush,
    output logic [INST_LEN-1:0]  inst,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic                 inst_fault,

    // Instruction memory side
    ysyx_22050039_inst_fetch_if.master mem
`ifdef YSYX_22050039_IFETCH_PERF_EN
    ,
    output logic [63:0]          perf_fetch,
    output logic [63:0]          perf_stall,
    output logic [63:0]          perf_flush
`endif
);

    ifetch_state_e state, state_nx;

    logic half_sel;     // pc[2] of the fetch in progress: 1 = upper word
    logic latch_half;   // capture pc[2] into half_sel this cycle
    logic load_inst;    // capture the response into inst/inst_fault

    // pc[1:0] never influences the fetch; the core guarantees alignment.
    logic pc_lo_unused;
    assign pc_lo_unused = ^pc[1:0];

    // Doubleword-aligned request address follows the live pc.
    assign mem.mem_req_addr = {pc[XLEN-1:3], 3'b000};

    // The instruction is offered only while sitting in DONE.
    assign inst_valid = (state == S_DONE);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state and control decode.
    // NOTE: every output of this block gets a default before the case
    // statement; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nx          = state;
        mem.mem_req_valid = 1'b0;
        latch_half        = 1'b0;
        load_inst         = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (pc_valid) begin
                    state_nx   = S_REQ;
                    latch_half = 1'b1;
                end
            end

            S_REQ: begin
                mem.mem_req_valid = 1'b1;
                // The address tracks pc until acceptance (a flush may change
                // it), so the half-select follows it cycle by cycle too. A
                // flush in the same cycle as acceptance is already carrying
                // the new address, so the request is kept.
                latch_half = 1'b1;
                if (mem.mem_req_ready) state_nx = S_WAIT;
            end

            S_WAIT: begin
                if (mem.mem_resp_valid) begin
                    if (flush) begin
                        // Response is for the old pc: drop it and refetch.
                        state_nx   = S_REQ;
                        latch_half = 1'b1;
                    end else begin
                        state_nx  = S_DONE;
                        load_inst = 1'b1;
                    end
                end else if (flush) begin
                    state_nx = S_DRAIN;
                end
            end

            S_DONE: begin
                if (inst_ready) begin
                    // Handshake completes; a concurrent flush just steers
                    // the next fetch to the redirected pc.
                    latch_half = 1'b1;
                    state_nx   = (pc_valid || flush) ? S_REQ : S_IDLE;
                end else if (flush) begin
                    latch_half = 1'b1;
                    state_nx   = S_REQ;
                end
            end

            S_DRAIN: begin
                // The stale response is discarded; only then may a new
                // request go out, keeping a single request in flight.
                if (mem.mem_resp_valid) begin
                    if (pc_valid || flush) begin
                        state_nx   = S_REQ;
                        latch_half = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end

            default: state_nx = S_IDLE;
        endcase
    end

    // Fetched instruction, fault flag and half-select registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst       <= NOP_INST[INST_LEN-1:0];
            inst_fault <= 1'b0;
            half_sel   <= 1'b0;
        end else begin
            if (load_inst) begin
                inst       <= half_sel ? mem.mem_resp_data[2*INST_LEN-1:INST_LEN]
                                       : mem.mem_resp_data[INST_LEN-1:0];
                inst_fault <= mem.mem_resp_err;
            end
            if (latch_half) half_sel <= pc[2];
        end
    end

`ifdef YSYX_22050039_IFETCH_PERF_EN
    logic fetch_evt;
    logic stall_evt;
    logic flush_evt;

    // Events fed to the counters; a flush in IDLE has nothing to redirect.
    always_comb begin
        fetch_evt = inst_valid && inst_ready;
        stall_evt = is_stall_state(state);
        flush_evt = flush && (state != S_IDLE);
    end

    ysyx_22050039_ifetch_perf u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_inc (fetch_evt),
        .stall_inc (stall_evt),
        .flush_inc (flush_evt),
        .fetch_cnt (perf_fetch),
        .stall_cnt (perf_stall),
        .flush_cnt (perf_flush)
    );
`endif

endmodule

// File: tb/tb_ysyx_22050039_inst_fetch.sv
// Self-checking bench for ysyx_22050039_inst_fetch. A transaction-level model
// tracks which memory response (if any) must reach the core, and with which
// half-word and fault flag; directed scenarios are followed by random traffic.
module tb_ysyx_22050039_inst_fetch;
    import ysyx_22050039_ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc = 64'h8000_0000;
    logic        pc_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        inst_fault;
`ifdef YSYX_22050039_IFETCH_PERF_EN
    logic [63:0] perf_fetch, perf_stall, perf_flush;
`endif

    ysyx_22050039_inst_fetch_if #(.XLEN(64), .MEM_DW(64)) mem_if ();

    ysyx_22050039_inst_fetch #(.XLEN(64), .INST_LEN(32), .MEM_DW(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_fault (inst_fault),
        .mem        (mem_if)
`ifdef YSYX_22050039_IFETCH_PERF_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall),
        .perf_flush (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_data  = '0;
        mem_if.mem_resp_err   = 1'b0;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Stimulus controls
    logic        c_rst = 1'b1, c_pc_valid = 1'b0, c_flush = 1'b0, c_ready = 1'b0;
    logic        c_req_ready = 1'b1;
    logic [63:0] c_pc = 64'h8000_0000;
    logic        new_pc_on_hs = 1'b0;
    int          lat_lo = 1, lat_hi = 1;
    logic        data_fixed = 1'b1;
    logic [63:0] fixed_data = 64'h00100093_00000413;
    logic        err_next = 1'b0, err_rand = 1'b0;

    // Memory + reference model
    logic        mem_pending = 1'b0;  // memory owes one response
    int          mem_wait = 0;
    logic        stale = 1'b0;        // owed response belongs to an abandoned fetch
    logic        have_inst = 1'b0;    // core must currently see a valid instruction
    logic        exp_half = 1'b0;
    logic [31:0] exp_inst = '0;
    logic        exp_fault = 1'b0;
    logic [63:0] hs_cnt = '0;
    int          idle_cycles = 0;
    logic        abort = 1'b0;

    // Observations of the last cycle
    logic        o_inst_valid, o_req_valid, o_fault, last_acc, last_hs;
    logic [31:0] o_inst;
    logic [63:0] o_addr, last_acc_addr;

    function automatic logic [63:0] rnd_pc();
        return 64'h8000_0000 + 64'({$urandom_range(0, 1023), 2'b00});
    endfunction

    // One clock cycle: drive at negedge, sample/check, advance the model.
    task automatic cycle();
        logic        resp, e, acc, hs;
        logic [63:0] d;
        @(negedge clk);
        if (new_pc_on_hs && inst_valid && c_ready) c_pc = rnd_pc();
        rst        = c_rst;
        pc         = c_pc;
        pc_valid   = c_pc_valid;
        flush      = c_flush;
        inst_ready = c_ready;
        mem_if.mem_req_ready = c_req_ready;
        resp = 1'b0;
        if (mem_pending) begin
            mem_wait--;
            if (mem_wait <= 0) resp = 1'b1;
        end
        d = data_fixed ? fixed_data : {$urandom, $urandom};
        e = err_next || (err_rand && ($urandom_range(0, 7) == 0));
        mem_if.mem_resp_valid = resp;
        mem_if.mem_resp_data  = d;
        mem_if.mem_resp_err   = resp & e;
        #1;
        o_inst_valid = inst_valid;
        o_inst       = inst;
        o_fault      = inst_fault;
        o_req_valid  = mem_if.mem_req_valid;
        o_addr       = mem_if.mem_req_addr;

        check("inst_valid", {63'd0, o_inst_valid}, {63'd0, have_inst});
        if (have_inst && o_inst_valid) begin
            check("inst", {32'd0, o_inst}, {32'd0, exp_inst});
            check("inst_fault", {63'd0, o_fault}, {63'd0, exp_fault});
        end
        if (o_req_valid) begin
            check("req_while_busy", {63'd0, mem_pending || have_inst}, 64'd0);
            check("req_addr", o_addr, {c_pc[63:3], 3'b000});
        end

        hs  = o_inst_valid && c_ready && !c_rst;
        acc = o_req_valid && c_req_ready && !c_rst;
        last_hs  = hs;
        last_acc = acc;
        if (acc) last_acc_addr = o_addr;

        if (resp) begin
            mem_pending = 1'b0;
            err_next    = 1'b0;
            if (!stale && !c_flush && !c_rst) begin
                have_inst = 1'b1;
                exp_inst  = exp_half ? d[63:32] : d[31:0];
                exp_fault = e;
            end
        end
        if (c_rst) begin
            have_inst = 1'b0;
            stale     = 1'b1;
            hs_cnt    = '0;
        end else begin
            if (hs) begin
                have_inst = 1'b0;
                hs_cnt++;
            end
            if (c_flush && have_inst) have_inst = 1'b0;
            if (c_flush && mem_pending) stale = 1'b1;
            if (acc) begin
                mem_pending = 1'b1;
                stale       = 1'b0;
                exp_half    = c_pc[2];
                mem_wait    = $urandom_range(lat_lo, lat_hi);
            end
        end

        if (hs || acc || resp || !c_pc_valid || c_rst) idle_cycles = 0;
        else idle_cycles++;
        if (idle_cycles > 100 && !abort) begin
            check("watchdog_progress", 64'd1, 64'd0);
            abort = 1'b1;
        end
    endtask

    // Run until the core sees a valid instruction; returns cycles taken.
    task automatic run_until_valid(input string tag, output int n);
        n = 0;
        while (n < 40) begin
            cycle();
            if (o_inst_valid) break;
            n++;
        end
        if (n >= 40) check({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        int n;
        int seen_target;

        // Reset
        cycle(); cycle();
        c_rst = 1'b0;
        cycle();
        check("rst_inst", {32'd0, o_inst}, {32'd0, NOP_INST});
        check("rst_fault", {63'd0, o_fault}, 64'd0);
        check("rst_req_valid", {63'd0, o_req_valid}, 64'd0);
`ifdef YSYX_22050039_IFETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch, 64'd0);
        check("rst_perf_stall", perf_stall, 64'd0);
`endif

        // Lower half, 3-cycle latency
        c_pc = 64'h8000_0000; c_pc_valid = 1'b1; c_ready = 1'b0;
        run_until_valid("t1", n);
        check("t1_latency", 64'(n), 64'd3);
        check("t1_inst_lo", {32'd0, o_inst}, 64'h0000_0413);
        c_pc_valid = 1'b0; c_ready = 1'b1;
        cycle();

        // Upper half
        c_pc = 64'h8000_0004; c_pc_valid = 1'b1; c_ready = 1'b0;
        run_until_valid("t2", n);
        check("t2_inst_hi", {32'd0, o_inst}, 64'h0010_0093);

        // Core back-pressure: held stable, no new request
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_hold_valid", {63'd0, o_inst_valid}, 64'd1);
            check("t3_hold_inst", {32'd0, o_inst}, 64'h0010_0093);
            check("t3_no_req", {63'd0, o_req_valid}, 64'd0);
        end
        lat_lo = 5; lat_hi = 5;
        c_pc = 64'h8000_0008; c_ready = 1'b1;
        cycle();
        c_ready = 1'b0;
        cycle();
        check("t3_req_after_hs", {63'd0, o_req_valid}, 64'd1);

        // Flush in WAIT; stale response comes 4 cycles later
        c_flush = 1'b1; c_pc = 64'h8000_0100; lat_lo = 1; lat_hi = 1;
        cycle();
        c_flush = 1'b0;
        seen_target = 0;
        n = 0;
        while (n < 40) begin
            cycle();
            if (last_acc && last_acc_addr == 64'h8000_0100) seen_target++;
            if (o_inst_valid) break;
            n++;
        end
        check("t4_refetch_cnt", 64'(seen_target), 64'd1);
        check("t4_inst", {32'd0, o_inst}, 64'h0000_0413);

        // Bus error then clean fetch
        c_pc = 64'h8000_0204; c_ready = 1'b1; err_next = 1'b1;
        cycle();
        c_ready = 1'b0;
        run_until_valid("t5a", n);
        check("t5_fault_set", {63'd0, o_fault}, 64'd1);
        check("t5_inst", {32'd0, o_inst}, 64'h0010_0093);
        c_pc = 64'h8000_0300; c_ready = 1'b1;
        cycle();
        c_ready = 1'b0;
        run_until_valid("t5b", n);
        check("t5_fault_clear", {63'd0, o_fault}, 64'd0);

        // Reset while waiting; late response must be ignored
        lat_lo = 4; lat_hi = 4; c_ready = 1'b1;
        cycle();
        c_ready = 1'b0;
        n = 0;
        while (!last_acc && n < 10) begin cycle(); n++; end
        c_rst = 1'b1; c_pc_valid = 1'b0;
        cycle();
        c_rst = 1'b0;
        cycle();
        check("t6_valid", {63'd0, o_inst_valid}, 64'd0);
        check("t6_inst_nop", {32'd0, o_inst}, {32'd0, NOP_INST});
`ifdef YSYX_22050039_IFETCH_PERF_EN
        check("t6_perf_fetch", perf_fetch, 64'd0);
        check("t6_perf_stall", perf_stall, 64'd0);
        check("t6_perf_flush", perf_flush, 64'd0);
`endif
        for (int i = 0; i < 6; i++) cycle();
        check("t6_idle_no_req", {63'd0, o_req_valid}, 64'd0);

        // Random traffic
        data_fixed = 1'b0; err_rand = 1'b1; new_pc_on_hs = 1'b1;
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000 && !abort; i++) begin
            c_flush = ($urandom_range(0, 19) == 0);
            if (c_flush) c_pc = rnd_pc();
            c_pc_valid  = c_flush || ($urandom_range(0, 9) != 0);
            c_ready     = ($urandom_range(0, 9) < 6);
            c_req_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
`ifdef YSYX_22050039_IFETCH_PERF_EN
        check("perf_fetch_total", perf_fetch, hs_cnt);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
